// File: rtl/counter_ctrl.sv
// Button front end and mode FSM for a downstream up/down counter: sync, debounce, press-edge, mode select.
// Optional build macro COUNTER_CTRL_AUTOSTOP_EN adds an idle timeout that drops UP/DOWN back to STOP.
module counter_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_btn_clr,
  output logic [1:0] o_ctrl
);

  localparam int NB = 3;  // bit 0 up, bit 1 down, bit 2 clr
  localparam int BI_UP = 0, BI_DN = 1, BI_CLR = 2;

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_UP    = 2'b01,
    ST_DOWN  = 2'b11,
    ST_CLEAR = 2'b10
  } state_t;

  logic [NB-1:0]       w_raw;
  logic [NB-1:0]       r_s1, r_s2, r_db, r_db_d;
  logic [NB-1:0][7:0]  r_cnt;
  logic [NB-1:0]       w_evt;
  state_t              r_state, w_state_nxt;
  logic [1:0]          r_ctrl, w_ctrl_nxt;
  logic                w_timeout;

  assign w_raw = {i_btn_clr, i_btn_down, i_btn_up};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_db   <= '0;
      r_db_d <= '0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= w_raw;
      r_s2   <= r_s1;
      r_db_d <= r_db;
      for (int i = 0; i < NB; i++) begin
        if (r_s2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == 8'(DB_CYCLES - 1)) begin
          r_cnt[i] <= '0;
          r_db[i]  <= ~r_db[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Press only; releases are deliberately silent.
  assign w_evt = r_db & ~r_db_d;

`ifdef COUNTER_CTRL_AUTOSTOP_EN
  logic [15:0] r_idle;
  logic        w_run;

  assign w_run     = (r_state == ST_UP) || (r_state == ST_DOWN);
  assign w_timeout = w_run && (r_idle == 16'(TIMEOUT - 1));

  // Counts only while staying in UP/DOWN with no press; any change of state restarts it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                            r_idle <= '0;
    else if (w_run && (w_state_nxt == r_state) && (w_evt == '0)) r_idle <= r_idle + 16'd1;
    else                                                     r_idle <= '0;
  end
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = (TIMEOUT > 0);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_STOP;
      r_ctrl  <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_ctrl  <= w_ctrl_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_evt[BI_CLR]) begin
      w_state_nxt = ST_CLEAR;
    end else if (r_state == ST_CLEAR) begin
      w_state_nxt = ST_STOP;
    end else if (w_evt[BI_UP] && w_evt[BI_DN]) begin
      w_state_nxt = ST_STOP;
    end else if (w_evt[BI_UP]) begin
      w_state_nxt = (r_state == ST_UP) ? ST_STOP : ST_UP;
    end else if (w_evt[BI_DN]) begin
      w_state_nxt = (r_state == ST_DOWN) ? ST_STOP : ST_DOWN;
    end else if (w_timeout) begin
      w_state_nxt = ST_STOP;
    end
  end

  // State encoding doubles as the ctrl word; registered so ctrl only moves on an edge.
  always_comb begin
    w_ctrl_nxt = 2'b00;
    case (w_state_nxt)
      ST_UP:    w_ctrl_nxt = 2'b01;
      ST_DOWN:  w_ctrl_nxt = 2'b11;
      ST_CLEAR: w_ctrl_nxt = 2'b10;
      default:  w_ctrl_nxt = 2'b00;
    endcase
  end

  assign o_ctrl = r_ctrl;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: vector table for mode sequencing plus hand sequences for clear, reset and timeout.
module tb_counter_ctrl;

  logic       clk, rst_n;
  logic       btn_up, btn_down, btn_clr;
  logic [1:0] ctrl;
  int         n_cmp, n_err;

  counter_ctrl #(.DB_CYCLES(4), .TIMEOUT(64)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_btn_up  (btn_up),
    .i_btn_down(btn_down),
    .i_btn_clr (btn_clr),
    .o_ctrl    (ctrl)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  typedef struct {
    logic       up;
    logic       dn;
    logic       clr;
    int         cyc;
    logic [1:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [1:0] exp);
    n_cmp++;
    if (ctrl !== exp) begin
      n_err++;
      $display("FAIL %s: ctrl=%b expected %b at %0t", name, ctrl, exp, $time);
    end
  endtask

  task automatic drive(input logic up, input logic dn, input logic clr);
    btn_up   = up;
    btn_down = dn;
    btn_clr  = clr;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    drive(0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("reset_state", 2'b00);
    #4;
    rst_n = 1'b1;

    // Idle after reset: ctrl stays 00 for 100 cycles
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_100", 2'b00);
    end

    // {up, dn, clr, cycles held, expected ctrl after the last edge}
    tbl.push_back('{1'b1, 1'b0, 1'b0,  6, 2'b00, "up_edge6_no_change"});
    tbl.push_back('{1'b1, 1'b0, 1'b0,  1, 2'b01, "up_edge7_enter_up"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 20, 2'b01, "up_held_single_event"});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 2'b01, "up_release_no_event"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 10, 2'b00, "up_toggle_to_stop"});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 2'b00, "release_stop"});
    tbl.push_back('{1'b1, 1'b0, 1'b0,  3, 2'b00, "glitch_up_3cyc"});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 2'b00, "glitch_no_event"});
    tbl.push_back('{1'b0, 1'b1, 1'b0,  6, 2'b00, "down_edge6_no_change"});
    tbl.push_back('{1'b0, 1'b1, 1'b0,  1, 2'b11, "down_edge7_enter_down"});
    tbl.push_back('{1'b0, 1'b1, 1'b0,  3, 2'b11, "down_held"});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 2'b11, "down_release"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 10, 2'b01, "down_to_up"});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 2'b01, "release_up"});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 10, 2'b11, "up_to_down"});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 2'b11, "release_down"});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 10, 2'b00, "down_toggle_to_stop"});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 2'b00, "release_stop2"});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 10, 2'b00, "both_from_stop"});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 2'b00, "release_both"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 10, 2'b01, "enter_up_again"});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 2'b01, "release_up2"});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 10, 2'b00, "both_from_up"});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 2'b00, "release_both2"});

    foreach (tbl[k]) begin
      drive(tbl[k].up, tbl[k].dn, tbl[k].clr);
      repeat (tbl[k].cyc) tick();
      chk(tbl[k].name, tbl[k].exp);
    end

    // Clear and down together while in UP: one cycle of 10, then 00
    drive(1, 0, 0);
    repeat (10) tick();
    chk("clr_setup_up", 2'b01);
    drive(0, 0, 0);
    repeat (10) tick();
    drive(0, 1, 1);
    repeat (6) tick();
    chk("clr_edge6_still_up", 2'b01);
    tick();
    chk("clr_edge7_clear", 2'b10);
    tick();
    chk("clr_edge8_stop", 2'b00);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("clr_held_stop", 2'b00);
    end
    drive(0, 0, 0);
    repeat (10) tick();
    chk("clr_release_stop", 2'b00);

    // Reset pulse mid-debounce while in DOWN with up held
    drive(0, 1, 0);
    repeat (10) tick();
    chk("rst_setup_down", 2'b11);
    drive(0, 0, 0);
    repeat (10) tick();
    drive(1, 0, 0);
    repeat (3) tick();
    #4 rst_n = 1'b0;
    #2 chk("rst_async_clear", 2'b00);
    #2 rst_n = 1'b1;
    repeat (6) tick();
    chk("rst_edge6_no_change", 2'b00);
    tick();
    chk("rst_edge7_fresh_press", 2'b01);

    // Up still held, no further presses: timeout behaviour
`ifdef COUNTER_CTRL_AUTOSTOP_EN
    for (int i = 1; i < 64; i++) begin
      tick();
      chk("autostop_hold_up", 2'b01);
    end
    tick();
    chk("autostop_fires", 2'b00);
    repeat (20) tick();
    chk("autostop_stays_stop", 2'b00);
`else
    repeat (64) tick();
    chk("no_autostop_64", 2'b01);
    repeat (936) tick();
    chk("no_autostop_1000", 2'b01);
`endif
    drive(0, 0, 0);
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 4: consecutive cycles a synchronized button level must differ from its debounced level before the debounced level flips; legal range 2..255.
REQ-002 SHALL have parameter TIMEOUT, default 64: idle cycles before auto-stop; used only under REQ-020; legal range 2..65535.
REQ-003 SHALL have clk, input, 1: single clock; all flops on rising edge.
REQ-004 SHALL have reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have btn_up, input, 1: raw asynchronous button, active-high; request count-up.
REQ-006 SHALL have btn_down, input, 1: raw asynchronous button, active-high; request count-down.
REQ-007 SHALL have btn_clr, input, 1: raw asynchronous button, active-high; request counter clear.
REQ-008 SHALL have ctrl, output, 2: registered mode word driving the downstream counter's ctrl input; 00 hold, 01 up, 11 down, 10 clear.

Function
REQ-009 SHALL pass each button through its own 2-flop synchronizer.
REQ-010 SHALL debounce each synchronized button with its own counter; mismatch cycle increments, matching cycle zeroes it; at DB_CYCLES consecutive mismatches the debounced level flips and the counter zeroes.
REQ-011 SHALL derive a one-cycle press event from each debounced 0->1 transition; release (1->0) produces no event.
REQ-012 SHALL implement FSM states STOP, UP, DOWN, CLEAR; ctrl registered: STOP 00, UP 01, DOWN 11, CLEAR 10.
REQ-013 Transitions on press events, priority clr > (up and down together) > single:
 - clr event from any state -> CLEAR;
 - CLEAR -> STOP after exactly one cycle, unconditionally; events arriving in that cycle other than clr are dropped;
 - up and down events in the same cycle -> STOP;
 - up: STOP->UP, DOWN->UP, UP->STOP (toggle);
 - down: STOP->DOWN, UP->DOWN, DOWN->STOP (toggle);
 - no event -> hold state.
REQ-014 Latency: raw button held high from just before rising edge 1 SHALL change ctrl at edge DB_CYCLES+3 and no earlier.
REQ-015 A button glitch shorter than DB_CYCLES synchronized cycles SHALL produce no event and no ctrl change.
REQ-016 Holding a button indefinitely SHALL produce exactly one event.
REQ-017 ctrl SHALL change only on a clk rising edge or on reset assertion; no combinational path from buttons to ctrl.

Reset
REQ-018 On reset low, asynchronously and immediately: synchronizers, debounced levels, debounce counters, timeout counter zero; FSM STOP; ctrl = 00.
REQ-019 Reset asserted mid-operation (including during CLEAR or mid-debounce) SHALL abort it; after release a button already held high SHALL be treated as a fresh press (one event after full latency).

Configuration
REQ-020 With COUNTER_CTRL_AUTOSTOP_EN defined: a 16-bit idle counter runs while in UP or DOWN, zeroes on any press event or on entering UP/DOWN, and after TIMEOUT consecutive idle cycles in UP/DOWN forces STOP (ctrl 00) on the next edge; counter held at 0 in STOP/CLEAR.
REQ-021 Without COUNTER_CTRL_AUTOSTOP_EN: no idle counter in the netlist; UP/DOWN held indefinitely; TIMEOUT ignored.

Verification (DB_CYCLES=4, TIMEOUT=64, 20 ns clock)
REQ-022 Reset low 5 ns then high, no buttons -> ctrl = 00 for 100 cycles.
REQ-023 btn_up high 10 cycles from STOP -> ctrl 01 at edge 7 after rise; second 10-cycle press -> ctrl 00.
REQ-024 btn_up pulse 3 cycles -> ctrl stays 00; then btn_down 10 cycles -> ctrl 11 at edge 7.
REQ-025 In UP, btn_clr and btn_down rise same cycle -> ctrl 10 for exactly one cycle, then 00.
REQ-026 Macro defined: enter UP, no presses -> ctrl 01 for 64 cycles then 00; macro undefined -> ctrl 01 after 1000 cycles.
REQ-027 In DOWN, reset pulsed low mid-cycle with btn_up held -> ctrl 00 immediately; after release ctrl 01 at edge 7.
